lut_sweep_reader: RTL and testbench



---
 rtl/lut_sweep_reader.sv | 152 +++++++++++++++
 tb/tb_lut_sweep_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lut_sweep_reader.sv
// lut_sweep_reader: walks every input code of one neuron LUT, packs the
// sampled outputs LSB-first into WORD_W-bit words and streams them out over
// valid/ready, while keeping a ones-count signature of the truth table.
module lut_sweep_reader #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int WORD_W   = 32,
  parameter int LUT_LAT  = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic [IN_BITS-1:0]                lut_addr,
  input  logic [OUT_BITS-1:0]               lut_data,
  output logic [WORD_W-1:0]                 m_tdata,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              m_tlast,
  output logic [IN_BITS+$clog2(OUT_BITS):0] ones_cnt
);

  localparam int EPW    = WORD_W / OUT_BITS;
  localparam int SW     = (EPW > 1) ? $clog2(EPW) : 1;
  localparam int ONES_W = IN_BITS + $clog2(OUT_BITS) + 1;
  localparam logic [1:0] LAT = 2'(LUT_LAT);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [IN_BITS-1:0]  addr_q;
  logic [1:0]          wait_q;
  logic [SW-1:0]       slot_q;     // entry position inside the word being packed
  logic [WORD_W-1:0]   pack_q;
  logic [ONES_W-1:0]   ones_q;
  logic [WORD_W-1:0]   tdata_q;
  logic                tvalid_q;
  logic                tlast_q;

  logic                wait_done, last_addr, word_end, hs, capture;
  logic [WORD_W-1:0]   pack_nx;
  logic [ONES_W-1:0]   pop;

  // Capture/stall decode: a word-completing capture must not overwrite an
  // output word that downstream has not yet taken.
  always_comb begin
    wait_done = (wait_q == 2'd0);
    last_addr = (addr_q == {IN_BITS{1'b1}});
    word_end  = (slot_q == SW'(EPW - 1)) || last_addr;
    hs        = tvalid_q & m_tready;
    capture   = (state_q == S_SAMPLE) && wait_done &&
                !(word_end && tvalid_q && !m_tready);
  end

  // Insert the current LUT sample into the pack word and count its ones.
  always_comb begin
    pack_nx = pack_q;
    pack_nx[slot_q*OUT_BITS +: OUT_BITS] = lut_data;
    pop = '0;
    for (int i = 0; i < OUT_BITS; i++) pop = pop + ONES_W'(lut_data[i]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_SAMPLE;
      S_SAMPLE: if (capture && last_addr) state_d = S_DRAIN;
      S_DRAIN:  if (hs) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = (state_q == S_SAMPLE) || (state_q == S_DRAIN);
    done = (state_q == S_DONE);
  end

  // Sweep datapath: address walk, latency wait, packing and signature.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      wait_q <= 2'd0;
      slot_q <= '0;
      pack_q <= '0;
      ones_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          addr_q <= '0;
          wait_q <= LAT;
          slot_q <= '0;
          pack_q <= '0;
          ones_q <= '0;
        end
        S_SAMPLE: begin
          if (!wait_done) begin
            wait_q <= wait_q - 2'd1;
          end else if (capture) begin
            ones_q <= ones_q + pop;
            if (word_end) begin
              pack_q <= '0;
              slot_q <= '0;
            end else begin
              pack_q <= pack_nx;
              slot_q <= slot_q + SW'(1);
            end
            if (!last_addr) begin
              addr_q <= addr_q + IN_BITS'(1);
              wait_q <= LAT;
            end
          end
        end
        S_DONE:  addr_q <= '0;
        default: ;
      endcase
    end
  end

  // Output register: loads on a word-completing capture, clears only on a
  // handshake, so data stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (capture && word_end) begin
      tdata_q  <= pack_nx;
      tvalid_q <= 1'b1;
      tlast_q  <= last_addr;
    end else if (hs) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end
  end

  assign lut_addr = addr_q;
  assign m_tdata  = tdata_q;
  assign m_tvalid = tvalid_q;
  assign m_tlast  = tlast_q;
  assign ones_cnt = ones_q;

endmodule

// File: tb/tb_lut_sweep_reader.sv
// Directed bench for lut_sweep_reader: three instances (default, LUT_LAT=2,
// partial final word) driven by per-scenario tasks with hand-computed results.
module tb_lut_sweep_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults, lut_data = addr[0]
  logic        a_start = 0, a_busy, a_done, a_tvalid, a_tready = 1, a_tlast;
  logic [7:0]  a_addr;
  logic [0:0]  a_data;
  logic [31:0] a_tdata;
  logic [8:0]  a_ones;
  assign a_data = a_addr[0];

  lut_sweep_reader u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .lut_addr(a_addr), .lut_data(a_data), .m_tdata(a_tdata), .m_tvalid(a_tvalid),
    .m_tready(a_tready), .m_tlast(a_tlast), .ones_cnt(a_ones));

  // Instance B: LUT_LAT=2, lut_data = ~addr[7] through a 2-deep register pipe
  logic        b_start = 0, b_busy, b_done, b_tvalid, b_tready = 1, b_tlast;
  logic [7:0]  b_addr;
  logic [0:0]  b_data;
  logic        b_r1, b_r2;
  logic [31:0] b_tdata;
  logic [8:0]  b_ones;
  always @(posedge clk) begin
    b_r1 <= ~b_addr[7];
    b_r2 <= b_r1;
  end
  assign b_data = b_r2;

  lut_sweep_reader #(.LUT_LAT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .lut_addr(b_addr), .lut_data(b_data), .m_tdata(b_tdata), .m_tvalid(b_tvalid),
    .m_tready(b_tready), .m_tlast(b_tlast), .ones_cnt(b_ones));

  // Instance C: IN_BITS=2, OUT_BITS=3, WORD_W=9, lut_data = addr+4
  logic        c_start = 0, c_busy, c_done, c_tvalid, c_tready = 1, c_tlast;
  logic [1:0]  c_addr;
  logic [2:0]  c_data;
  logic [8:0]  c_tdata;
  logic [4:0]  c_ones;
  assign c_data = {1'b0, c_addr} + 3'd4;

  lut_sweep_reader #(.IN_BITS(2), .OUT_BITS(3), .WORD_W(9)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .busy(c_busy), .done(c_done),
    .lut_addr(c_addr), .lut_data(c_data), .m_tdata(c_tdata), .m_tvalid(c_tvalid),
    .m_tready(c_tready), .m_tlast(c_tlast), .ones_cnt(c_ones));

  int n_cmp = 0;
  int n_err = 0;

  // Results of the last run
  logic [31:0] words[$];
  bit          lasts[$];
  int ndone, nbusy, tail_busy, hold_err, stall_addr;
  bit timeout;

  task automatic drive(input int sel, input logic st, input logic rdy);
    case (sel)
      0: begin a_start = st; a_tready = rdy; end
      1: begin b_start = st; b_tready = rdy; end
      default: begin c_start = st; c_tready = rdy; end
    endcase
  endtask

  // Runs one sweep on instance sel from a start pulse until a few cycles
  // after done. stall_len: cycles of m_tready=0 after first valid word.
  // restart_at: cycle to pulse start again (-2: in the done cycle, -1: never).
  task automatic run(input int sel, input int stall_len, input int restart_at);
    int fv_cyc, done_cyc;
    logic v, l, bz, dn, rdy, prev_hold;
    logic [31:0] d, prev;
    int ad;
    words.delete(); lasts.delete();
    ndone = 0; nbusy = 0; tail_busy = 0; hold_err = 0; stall_addr = -1; timeout = 0;
    fv_cyc = -1; done_cyc = -1; prev_hold = 0; prev = '0;
    @(negedge clk);
    drive(sel, 1'b1, 1'b1);
    @(negedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case (sel)
        0: begin v = a_tvalid; d = a_tdata; l = a_tlast; bz = a_busy; dn = a_done; ad = int'(a_addr); end
        1: begin v = b_tvalid; d = b_tdata; l = b_tlast; bz = b_busy; dn = b_done; ad = int'(b_addr); end
        default: begin v = c_tvalid; d = {23'd0, c_tdata}; l = c_tlast; bz = c_busy; dn = c_done; ad = int'(c_addr); end
      endcase
      if (v && fv_cyc < 0) fv_cyc = cyc;
      rdy = !(fv_cyc >= 0 && cyc >= fv_cyc && cyc < fv_cyc + stall_len);
      if (stall_len > 0 && fv_cyc >= 0 && cyc == fv_cyc + stall_len - 1) stall_addr = ad;
      if (prev_hold && (!v || d !== prev)) hold_err++;
      prev_hold = v && !rdy;
      prev = d;
      if (v && rdy) begin words.push_back(d); lasts.push_back(l); end
      if (bz) nbusy++;
      if (bz && done_cyc >= 0) tail_busy++;
      if (dn) begin ndone++; if (done_cyc < 0) done_cyc = cyc; end
      drive(sel, (cyc == restart_at) || (restart_at == -2 && cyc == done_cyc), rdy);
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
      @(negedge clk);
    end
    drive(sel, 1'b0, 1'b1);
    timeout = (done_cyc < 0);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", a_busy); end
    n_cmp++; if (a_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", a_done); end
    n_cmp++; if (a_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", a_tvalid); end
    n_cmp++; if (a_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got %b want 0", a_tlast); end
    n_cmp++; if (a_tdata !== 32'h0) begin n_err++; $display("FAIL reset_tdata got %h want 0", a_tdata); end
    n_cmp++; if (a_ones !== 9'd0) begin n_err++; $display("FAIL reset_ones got %0d want 0", a_ones); end
    n_cmp++; if (a_addr !== 8'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", a_addr); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic_sweep();
    run(0, 0, -1);
    n_cmp++; if (timeout) begin n_err++; $display("FAIL basic_timeout got no done want done"); end
    n_cmp++; if (words.size() != 8) begin n_err++; $display("FAIL basic_nwords got %0d want 8", words.size()); end
    for (int i = 0; i < words.size(); i++) begin
      n_cmp++; if (words[i] !== 32'hAAAAAAAA) begin n_err++; $display("FAIL basic_word%0d got %h want aaaaaaaa", i, words[i]); end
      n_cmp++; if (lasts[i] !== (i == 7)) begin n_err++; $display("FAIL basic_tlast%0d got %b want %b", i, lasts[i], i == 7); end
    end
    n_cmp++; if (a_ones !== 9'd128) begin n_err++; $display("FAIL basic_ones got %0d want 128", a_ones); end
    n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL basic_done_pulses got %0d want 1", ndone); end
    n_cmp++; if (nbusy < 255 || nbusy > 260) begin n_err++; $display("FAIL basic_busy_cycles got %0d want 255..260", nbusy); end
    n_cmp++; if (a_addr !== 8'd0) begin n_err++; $display("FAIL basic_idle_addr got %0d want 0", a_addr); end
  endtask

  task automatic test_backpressure();
    run(0, 40, -1);
    n_cmp++; if (timeout) begin n_err++; $display("FAIL bp_timeout got no done want done"); end
    n_cmp++; if (stall_addr != 63) begin n_err++; $display("FAIL bp_stall_addr got %0d want 63", stall_addr); end
    n_cmp++; if (hold_err != 0) begin n_err++; $display("FAIL bp_hold got %0d unstable cycles want 0", hold_err); end
    n_cmp++; if (words.size() != 8) begin n_err++; $display("FAIL bp_nwords got %0d want 8", words.size()); end
    for (int i = 0; i < words.size(); i++) begin
      n_cmp++; if (words[i] !== 32'hAAAAAAAA) begin n_err++; $display("FAIL bp_word%0d got %h want aaaaaaaa", i, words[i]); end
    end
    n_cmp++; if (a_ones !== 9'd128) begin n_err++; $display("FAIL bp_ones got %0d want 128", a_ones); end
    n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL bp_done_pulses got %0d want 1", ndone); end
  endtask

  task automatic test_latency();
    logic [31:0] exp;
    run(1, 0, -1);
    n_cmp++; if (timeout) begin n_err++; $display("FAIL lat_timeout got no done want done"); end
    n_cmp++; if (words.size() != 8) begin n_err++; $display("FAIL lat_nwords got %0d want 8", words.size()); end
    for (int i = 0; i < words.size(); i++) begin
      exp = (i < 4) ? 32'hFFFFFFFF : 32'h0;
      n_cmp++; if (words[i] !== exp) begin n_err++; $display("FAIL lat_word%0d got %h want %h", i, words[i], exp); end
    end
    n_cmp++; if (b_ones !== 9'd128) begin n_err++; $display("FAIL lat_ones got %0d want 128", b_ones); end
    n_cmp++; if (nbusy < 766 || nbusy > 772) begin n_err++; $display("FAIL lat_busy_cycles got %0d want 766..772", nbusy); end
  endtask

  task automatic test_partial_word();
    run(2, 0, -1);
    n_cmp++; if (timeout) begin n_err++; $display("FAIL part_timeout got no done want done"); end
    n_cmp++; if (words.size() != 2) begin n_err++; $display("FAIL part_nwords got %0d want 2", words.size()); end
    if (words.size() == 2) begin
      n_cmp++; if (words[0] !== 32'h1AC) begin n_err++; $display("FAIL part_word0 got %h want 1ac", words[0]); end
      n_cmp++; if (words[1] !== 32'h007) begin n_err++; $display("FAIL part_word1 got %h want 007", words[1]); end
      n_cmp++; if (lasts[0] !== 1'b0 || lasts[1] !== 1'b1) begin n_err++; $display("FAIL part_tlast got %b%b want 01", lasts[0], lasts[1]); end
    end
    n_cmp++; if (c_ones !== 5'd8) begin n_err++; $display("FAIL part_ones got %0d want 8", c_ones); end
  endtask

  task automatic test_start_while_busy();
    run(0, 0, 50);
    n_cmp++; if (timeout) begin n_err++; $display("FAIL busy_start_timeout got no done want done"); end
    n_cmp++; if (words.size() != 8) begin n_err++; $display("FAIL busy_start_nwords got %0d want 8", words.size()); end
    for (int i = 0; i < words.size(); i++) begin
      n_cmp++; if (words[i] !== 32'hAAAAAAAA) begin n_err++; $display("FAIL busy_start_word%0d got %h want aaaaaaaa", i, words[i]); end
    end
    n_cmp++; if (a_ones !== 9'd128) begin n_err++; $display("FAIL busy_start_ones got %0d want 128", a_ones); end
    // start pulsed in the DONE cycle must not launch a new sweep
    run(0, 0, -2);
    n_cmp++; if (tail_busy != 0) begin n_err++; $display("FAIL done_start got busy %0d cycles want 0", tail_busy); end
    n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL done_start_pulses got %0d want 1", ndone); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    @(negedge clk); a_start = 1;
    @(negedge clk); a_start = 0;
    n = 0;
    while (a_addr !== 8'd100 && n < 1000) begin @(negedge clk); n++; end
    n_cmp++; if (n >= 1000) begin n_err++; $display("FAIL rst_mid_reach got addr %0d want 100", a_addr); end
    rst_n = 0;
    #1;
    n_cmp++; if (a_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid_tvalid got %b want 0", a_tvalid); end
    n_cmp++; if (a_addr !== 8'd0) begin n_err++; $display("FAIL rst_mid_addr got %0d want 0", a_addr); end
    n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", a_busy); end
    n_cmp++; if (a_ones !== 9'd0) begin n_err++; $display("FAIL rst_mid_ones got %0d want 0", a_ones); end
    @(negedge clk);
    n_cmp++; if (a_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done got %b want 0", a_done); end
    rst_n = 1;
    repeat (2) @(negedge clk);
    run(0, 0, -1);
    n_cmp++; if (timeout) begin n_err++; $display("FAIL rst_resweep_timeout got no done want done"); end
    n_cmp++; if (words.size() != 8) begin n_err++; $display("FAIL rst_resweep_nwords got %0d want 8", words.size()); end
    for (int i = 0; i < words.size(); i++) begin
      n_cmp++; if (words[i] !== 32'hAAAAAAAA) begin n_err++; $display("FAIL rst_resweep_word%0d got %h want aaaaaaaa", i, words[i]); end
    end
    n_cmp++; if (a_ones !== 9'd128) begin n_err++; $display("FAIL rst_resweep_ones got %0d want 128", a_ones); end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_backpressure();
    test_latency();
    test_partial_word();
    test_start_while_busy();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
